calc_exec_ctrl: RTL

Execution sequencer for the keypad calculator. Takes two 6-digit packed-BCD operands and a 4-bit opcode from the input controller and a start pulse on '='. Converts the operands to binary, then runs add, subtract, shift-add multiply or restoring divide. Converts the result back to BCD and presents it as `num_result` for the display path and the next chained operation.

---
 rtl/calc_pkg.sv | 36 +++
 rtl/calc_bin2bcd.sv | 36 +++
 rtl/calc_exec_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants, state encoding and BCD helpers for the calculator
// execution path and the display path.
package calc_pkg;

    localparam logic [3:0]  OP_ADD  = 4'ha;
    localparam logic [3:0]  OP_SUB  = 4'hb;
    localparam logic [3:0]  OP_MUL  = 4'hc;
    localparam logic [3:0]  OP_DIV  = 4'hd;
    localparam logic [3:0]  KEY_EQ  = 4'he;
    localparam logic [19:0] MAX_VAL = 20'd999999;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        LOAD = 5'b00010,
        EXEC = 5'b00100,
        CONV = 5'b01000,
        DONE = 5'b10000
    } state_t;

    function automatic logic op_ok(input logic [3:0] o);
        return (o >= OP_ADD) && (o <= OP_DIV);
    endfunction

    // Double-dabble adjust: add 3 to every digit that is 5 or more
    function automatic logic [23:0] dabble(input logic [23:0] d);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) begin
            if (d[i*4 +: 4] > 4'd4)
                r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
            else
                r[i*4 +: 4] = d[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Serial double-dabble, 20-bit binary to 6-digit packed BCD.
// The go edge performs the first of 20 steps; rdy returns after the last.
module calc_bin2bcd
    import calc_pkg::*;
(
    input  logic        CLK_1K,
    input  logic        RST,
    input  logic        go,
    input  logic [19:0] bin,
    output logic [23:0] bcd,
    output logic        rdy
);

    logic [19:0] sh;
    logic [4:0]  cnt;
    logic [43:0] nxt;

    assign nxt = {dabble(bcd), sh};
    assign rdy = (cnt == 5'd0);

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (go) begin
            bcd <= {23'd0, bin[19]};
            sh  <= {bin[18:0], 1'b0};
            cnt <= 5'd19;
        end else if (cnt != 5'd0) begin
            {bcd, sh} <= {nxt[42:0], 1'b0};
            cnt       <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/calc_exec_ctrl.sv
// Calculator execution sequencer: BCD load, add/sub/mul/div core,
// BCD conversion of the result and the done handshake.
module calc_exec_ctrl
    import calc_pkg::*;
(
    input  logic        CLK_1K,
    input  logic        RST,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [23:0] num_a,
    input  logic [23:0] num_b,
    output logic        busy,
    output logic        done,
    output logic [23:0] num_result,
    output logic        neg,
    output logic        err
);

    state_t      state;
    logic [3:0]  op;
    logic [23:0] sa, sb;
    logic [19:0] a_bin, b_bin;
    logic [39:0] acc;
    logic [4:0]  cnt;
    logic        bad, neg_r;

    logic [3:0]  dig_a, dig_b;
    logic [19:0] a_nxt, b_nxt;
    logic        load_bad;

    assign dig_a    = sa[23:20];
    assign dig_b    = sb[23:20];
    assign a_nxt    = {a_bin[16:0], 3'b000} + {a_bin[18:0], 1'b0}
                    + {16'd0, dig_a};
    assign b_nxt    = {b_bin[16:0], 3'b000} + {b_bin[18:0], 1'b0}
                    + {16'd0, dig_b};
    assign load_bad = bad || (dig_a > 4'd9) || (dig_b > 4'd9);

    logic [20:0] sum21, trial, diff21;
    logic [39:0] mul_step, div_step, res40;
    logic        sub_neg, last;

    // acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        sum21    = {1'b0, acc[39:20]} + (acc[0] ? {1'b0, a_bin} : 21'd0);
        mul_step = {sum21, acc[19:1]};
        trial    = {acc[39:20], acc[19]};
        diff21   = trial - {1'b0, b_bin};
        if (trial >= {1'b0, b_bin})
            div_step = {diff21[19:0], acc[18:0], 1'b1};
        else
            div_step = {trial[19:0], acc[18:0], 1'b0};
        sub_neg = (a_bin < b_bin);
        res40   = '0;
        case (op)
            OP_ADD: res40 = {19'd0, {1'b0, a_bin} + {1'b0, b_bin}};
            OP_SUB: res40 = {20'd0, sub_neg ? b_bin - a_bin : a_bin - b_bin};
            OP_MUL: res40 = mul_step;
            default: res40 = {20'd0, div_step[19:0]};
        endcase
        last = (op == OP_ADD) || (op == OP_SUB) || (cnt == 5'd19);
    end

    logic        conv_go, conv_rdy;
    logic [23:0] conv_bcd;

    assign conv_go = (state == EXEC) && last;

    calc_bin2bcd u_bin2bcd (
        .CLK_1K (CLK_1K),
        .RST    (RST),
        .go     (conv_go),
        .bin    (res40[19:0]),
        .bcd    (conv_bcd),
        .rdy    (conv_rdy)
    );

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            op         <= '0;
            sa         <= '0;
            sb         <= '0;
            a_bin      <= '0;
            b_bin      <= '0;
            acc        <= '0;
            cnt        <= '0;
            bad        <= 1'b0;
            neg_r      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            num_result <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa    <= num_a;
                    sb    <= num_b;
                    op    <= opcode;
                    a_bin <= '0;
                    b_bin <= '0;
                    cnt   <= '0;
                    bad   <= !op_ok(opcode);
                    busy  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    sa    <= {sa[19:0], 4'h0};
                    sb    <= {sb[19:0], 4'h0};
                    a_bin <= a_nxt;
                    b_bin <= b_nxt;
                    bad   <= load_bad;
                    cnt   <= cnt + 5'd1;
                    acc   <= (op == OP_MUL) ? {20'd0, b_nxt} : {20'd0, a_nxt};
                    if (cnt == 5'd5) begin
                        cnt <= '0;
                        if (load_bad || (op == OP_DIV && b_nxt == 20'd0)) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            err        <= 1'b1;
                            neg        <= 1'b0;
                            num_result <= '0;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc   <= (op == OP_MUL) ? mul_step : div_step;
                    cnt   <= cnt + 5'd1;
                    neg_r <= (op == OP_SUB) && sub_neg;
                    if (last) begin
                        if (res40 > {20'd0, MAX_VAL}) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            err        <= 1'b1;
                            neg        <= 1'b0;
                            num_result <= '0;
                        end else begin
                            state <= CONV;
                        end
                    end
                end
                CONV: if (conv_rdy) begin
                    state      <= DONE;
                    done       <= 1'b1;
                    err        <= 1'b0;
                    neg        <= neg_r;
                    num_result <= conv_bcd;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
